// File: rtl/mux_scanner_if.sv
// Sample bus between a mux_scanner and its consumer: data/select/enable
// inputs, mode control and the valid/ready sample handshake.
interface mux_scanner_if #(
    parameter int NCH = 2,
    parameter int NIN = 4,
    parameter int W   = 1
);
    localparam int SELW = $clog2(NIN);

    logic [NCH*NIN*W-1:0] I;
    logic [SELW-1:0]      S;
    logic [NCH-1:0]       EN_N;
    logic                 MODE;
    logic                 Y_READY;
    logic [NCH*W-1:0]     Y;
    logic [SELW-1:0]      Y_SEL;
    logic                 Y_VALID;

    modport master (
        output I, S, EN_N, MODE, Y_READY,
        input  Y, Y_SEL, Y_VALID
    );

    modport slave (
        input  I, S, EN_N, MODE, Y_READY,
        output Y, Y_SEL, Y_VALID
    );
endinterface

// File: rtl/mux_scanner.sv
// Multi-channel registered mux with direct-select and auto-scan modes;
// scan samples are presented on a valid/ready handshake.
module mux_scanner #(
    parameter int NCH   = 2,
    parameter int NIN   = 4,
    parameter int W     = 1,
    parameter int DWELL = 1
) (
    input  logic        CLK,
    input  logic        RST,
    mux_scanner_if.slave bus
);
    localparam int SELW = $clog2(NIN);
    localparam int CW   = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        ST_DIRECT,
        ST_DWELL,
        ST_PRESENT
    } state_t;

    state_t           state;
    logic [SELW-1:0]  idx;
    logic [CW-1:0]    cnt;
    logic [NCH*W-1:0] y_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;

    logic [NCH*W-1:0] cap_s;
    logic [NCH*W-1:0] cap_i;

    // Disabled channels capture zero rather than holding old data.
    always_comb begin
        cap_s = '0;
        cap_i = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!bus.EN_N[c]) begin
                cap_s[c*W +: W] =
                    bus.I[(c*NIN + int'(bus.S))*W +: W];
                cap_i[c*W +: W] =
                    bus.I[(c*NIN + int'(idx))*W +: W];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_DIRECT;
            idx     <= '0;
            cnt     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_DIRECT: begin
                    if (bus.MODE) begin
                        valid_q <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                        state   <= ST_DWELL;
                    end else begin
                        y_q     <= cap_s;
                        sel_q   <= bus.S;
                        valid_q <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (!bus.MODE) begin
                        y_q     <= cap_s;
                        sel_q   <= bus.S;
                        valid_q <= 1'b1;
                        state   <= ST_DIRECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DWELL - 1)) begin
                            y_q     <= cap_i;
                            sel_q   <= idx;
                            valid_q <= 1'b1;
                            state   <= ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    // Mode change wins over a same-edge accept.
                    if (!bus.MODE) begin
                        y_q     <= cap_s;
                        sel_q   <= bus.S;
                        valid_q <= 1'b1;
                        state   <= ST_DIRECT;
                    end else if (bus.Y_READY) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        idx     <= idx + 1'b1;
                        state   <= ST_DWELL;
                    end
                end
                default: begin
                    state   <= ST_DIRECT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y       = y_q;
    assign bus.Y_SEL   = sel_q;
    assign bus.Y_VALID = valid_q;
endmodule

// File: tb/tb_mux_scanner.sv
// Scoreboard bench for mux_scanner: three configurations share one
// clock/reset and one expected-sample queue.
module tb_mux_scanner;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scanner_if #(.NCH(2), .NIN(4), .W(1)) ifa ();
    mux_scanner_if #(.NCH(2), .NIN(4), .W(1)) ifb ();
    mux_scanner_if #(.NCH(2), .NIN(8), .W(4)) ifc ();

    mux_scanner #(.NCH(2), .NIN(4), .W(1), .DWELL(3)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa)
    );
    mux_scanner #(.NCH(2), .NIN(4), .W(1), .DWELL(4)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb)
    );
    mux_scanner #(.NCH(2), .NIN(8), .W(4), .DWELL(1)) dut_c (
        .CLK(clk), .RST(rst), .bus(ifc)
    );

    typedef struct {
        int          id;
        logic [63:0] data;
        int          gap;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   last[3];

    task automatic push(input int id, input logic [63:0] d,
                        input int gap, input string nm);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.gap  = gap;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic mon(input int id, input logic [63:0] obs);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_extra dut%0d got=%h want=none", id, obs);
        end else begin
            e = sbq.pop_front();
            if (e.id != id || e.data != obs ||
                (e.gap != 0 && cyc - last[id] != e.gap)) begin
                bad++;
                $display("FAIL %s dut%0d got=%h gap=%0d want dut%0d=%h gap=%0d",
                         e.name, id, obs, cyc - last[id],
                         e.id, e.data, e.gap);
            end
        end
        last[id] = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.Y_VALID && ifa.Y_READY)
                mon(0, 64'({ifa.Y, ifa.Y_SEL}));
            if (ifb.Y_VALID && ifb.Y_READY)
                mon(1, 64'({ifb.Y, ifb.Y_SEL}));
            if (ifc.Y_VALID && ifc.Y_READY)
                mon(2, 64'({ifc.Y, ifc.Y_SEL}));
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.I = '0; ifa.S = '0; ifa.EN_N = '0;
        ifa.MODE = 1'b0; ifa.Y_READY = 1'b0;
        ifb.I = '0; ifb.S = '0; ifb.EN_N = '0;
        ifb.MODE = 1'b0; ifb.Y_READY = 1'b0;
        ifc.I = '0; ifc.S = '0; ifc.EN_N = '0;
        ifc.MODE = 1'b0; ifc.Y_READY = 1'b0;
        #1;
        chk("rst_a", 64'({ifa.Y_VALID, ifa.Y, ifa.Y_SEL}), 64'd0);
        chk("rst_c", 64'({ifc.Y_VALID, ifc.Y, ifc.Y_SEL}), 64'd0);
        step(2);
        rst = 1'b0;

        // direct mode on A
        ifa.I = 8'b0000_0100; ifa.S = 2'd2; ifa.EN_N = 2'b00;
        ifa.Y_READY = 1'b1;
        push(0, 64'h6, 0, "dir_sel2");
        step(1);
        ifa.EN_N = 2'b01;
        push(0, 64'h2, 0, "dir_en_off");
        step(1);
        ifa.I = 8'b1000_0100; ifa.S = 2'd3; ifa.EN_N = 2'b00;
        push(0, 64'hB, 0, "dir_sel3");
        step(1);
        @(negedge clk); #1;
        ifa.Y_READY = 1'b0;

        // scan on A, DWELL=3, ch1 = 1010
        ifa.I = 8'b1010_0000; ifa.EN_N = 2'b00; ifa.MODE = 1'b1;
        step(1);
        ifa.Y_READY = 1'b1;
        push(0, 64'h0, 0, "scan_s0");
        push(0, 64'h9, 4, "scan_s1");
        push(0, 64'h2, 4, "scan_s2");
        push(0, 64'hB, 4, "scan_s3");
        push(0, 64'h0, 4, "scan_wrap");
        step(20);
        ifa.Y_READY = 1'b0;
        step(3);

        // backpressure holding sel 1
        chk("bp_start", 64'({ifa.Y_VALID, ifa.Y, ifa.Y_SEL}), 64'h19);
        for (int i = 0; i < 10; i++) begin
            ifa.I = ~ifa.I;
            ifa.S = ifa.S + 2'd1;
            ifa.EN_N = ~ifa.EN_N;
            step(1);
            chk("bp_hold", 64'({ifa.Y_VALID, ifa.Y, ifa.Y_SEL}), 64'h19);
        end
        ifa.I = 8'b1010_0000; ifa.EN_N = 2'b00;
        push(0, 64'h9, 0, "bp_release");
        ifa.Y_READY = 1'b1;
        step(1);
        chk("bp_drop", 64'(ifa.Y_VALID), 64'd0);
        push(0, 64'h2, 4, "bp_next_s2");
        step(4);
        ifa.Y_READY = 1'b0;
        step(3);

        // async reset while presenting sel 3
        chk("pre_rst", 64'({ifa.Y_VALID, ifa.Y, ifa.Y_SEL}), 64'h1B);
        #1 rst = 1'b1;
        #1 chk("async_rst", 64'({ifa.Y_VALID, ifa.Y, ifa.Y_SEL}), 64'd0);
        #1 rst = 1'b0;
        step(1);
        ifa.Y_READY = 1'b1;
        push(0, 64'h0, 0, "rst_restart_s0");
        push(0, 64'h9, 4, "rst_restart_s1");
        step(8);
        ifa.Y_READY = 1'b0;
        ifa.MODE = 1'b0;

        // mode exit on B, DWELL=4, at cnt=1
        ifb.I = 8'b0110_1000; ifb.EN_N = 2'b00; ifb.MODE = 1'b1;
        step(2);
        ifb.MODE = 1'b0; ifb.S = 2'd3; ifb.Y_READY = 1'b1;
        push(1, 64'h7, 0, "exit_sel3");
        step(1);
        chk("exit_valid", 64'(ifb.Y_VALID), 64'd1);
        ifb.S = 2'd1;
        push(1, 64'h9, 1, "exit_direct");
        step(1);
        @(negedge clk); #1;
        ifb.Y_READY = 1'b0;

        // wrap and width on C: NIN=8, W=4, DWELL=1
        ifc.I = 64'h89AB_CDEF_8765_4321;
        ifc.EN_N = 2'b00; ifc.MODE = 1'b1;
        step(1);
        ifc.Y_READY = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push(2, 64'({4'(15 - (k % 8)), 4'((k % 8) + 1), 3'(k % 8)}),
                 (k == 0) ? 0 : 2, "wide_scan");
        end
        step(17);
        @(negedge clk); #1;
        ifc.Y_READY = 1'b0;
        ifc.MODE = 1'b0;

        step(3);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of independent mux channels.
REQ-002 SHALL have parameter NIN, default 4, meaning inputs per channel; NIN is a power of 2 and at least 2.
REQ-003 SHALL have parameter W, default 1, meaning the data width of each input.
REQ-004 SHALL have parameter DWELL, default 1, meaning the settle cycles per scan step; DWELL is at least 1.
REQ-005 SHALL derive SELW = clog2(NIN).
REQ-006 SHALL have ports as follows (clock and reset first):
- CLK  input  1  sole clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- I  input  NCH*NIN*W  data; channel c, input k occupies bits [(c*NIN+k)*W +: W].
- S  input  SELW  shared select, used in direct mode.
- EN_N  input  NCH  per-channel active-low enable.
- MODE  input  1  0 = direct, 1 = scan.
- Y_READY  input  1  downstream accepts the sample.
- Y  output  NCH*W  registered mux outputs; channel c occupies bits [c*W +: W].
- Y_SEL  output  SELW  select index that produced the current Y.
- Y_VALID  output  1  Y/Y_SEL hold a valid sample.

Function
REQ-007 SHALL implement the FSM states DIRECT, DWELL and PRESENT, plus internal registers idx (SELW bits) and cnt (clog2(DWELL+1) bits).
REQ-008 SHALL, on each capture, load Y slice c with I[c][sel] when EN_N[c]=0, else with 0, where EN_N is sampled on the same edge.
REQ-009 SHALL, in DIRECT, on every edge capture with sel=S, set Y_SEL<=S and Y_VALID<=1; latency is 1 cycle and Y_READY is ignored.
REQ-010 SHALL, in DIRECT with MODE=1, on the next edge set Y_VALID<=0, idx<=0, cnt<=0 and go to DWELL.
REQ-011 SHALL, in DWELL, increment cnt each edge; on the edge where cnt==DWELL-1 it SHALL capture with sel=idx, set Y_SEL<=idx and Y_VALID<=1, and go to PRESENT.
REQ-012 SHALL, in PRESENT with Y_READY=0, hold Y, Y_SEL and Y_VALID=1 stable regardless of changes on I, EN_N or S.
REQ-013 SHALL, in PRESENT with Y_READY=1, on the edge set Y_VALID<=0, cnt<=0, idx<=idx+1 (NIN-1 wraps to 0) and go to DWELL.
REQ-014 SHALL, in DWELL or PRESENT with MODE=0, go to DIRECT on the next edge and perform the direct capture on that edge; any unaccepted sample is abandoned.
REQ-015 SHALL, with Y_READY held at 1 in scan mode, produce one Y_VALID pulse every DWELL+1 cycles, with Y_SEL running 0,1,...,NIN-1,0,...
REQ-016 SHALL give MODE priority over Y_READY when both change on the same edge.
REQ-017 SHALL treat all EN_N bits high as a valid all-zero sample, not as suppression of Y_VALID.

Reset
REQ-018 SHALL, while RST=1 and without waiting for a CLK edge, force Y=0, Y_SEL=0, Y_VALID=0, idx=0, cnt=0 and state DIRECT.
REQ-019 SHALL, on the first edge after RST falls, perform DIRECT behaviour if MODE=0 or the DIRECT-to-DWELL entry if MODE=1.
REQ-020 SHALL, when reset is asserted mid-scan, discard the sample in flight; the scan restarts at idx 0.

Verification (NCH=2, NIN=4, W=1 unless stated)
REQ-021 SHALL cover direct mode: I ch0 = 4'b0100, S=2, EN_N=00, MODE=0 -> Y[0]=1 and Y_SEL=2 one edge later; then EN_N=01 -> Y[0]=0 on the next edge.
REQ-022 SHALL cover scan mode with DWELL=3 and Y_READY=1: I ch1 = 4'b1010 -> Y_VALID pulses every 4 cycles, Y_SEL = 0,1,2,3,0 and Y[1] = 0,1,0,1,0.
REQ-023 SHALL cover backpressure: Y_READY=0 at PRESENT with Y_SEL=1, toggle all of I for 10 cycles -> Y, Y_SEL and Y_VALID unchanged; Y_READY=1 -> Y_VALID=0 next edge and the next sample has Y_SEL=2.
REQ-024 SHALL cover mode exit: MODE 1->0 at cnt=1 of DWELL=4 with S=3 -> on the next edge Y_SEL=3, Y_VALID=1 and state DIRECT.
REQ-025 SHALL cover asynchronous reset: RST pulsed between edges during PRESENT -> Y, Y_SEL and Y_VALID become 0 before the next edge; after release with MODE=1 the first sample has Y_SEL=0.
REQ-026 SHALL cover wrap and width: NIN=8, W=4, DWELL=1, Y_READY=1 -> Y_SEL = 7 then 0, with each 4-bit Y slice matching I.
